axi_b_responder: RTL and testbench

//  Slave-side write-response generator for the AXI write path: the responder end of the B

---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_b_responder_if.sv | 29 ++
 rtl/resp_fifo.sv | 45 ++++
 rtl/axi_b_responder.sv | 118 +++++++++++
 tb/tb_axi_b_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared response codes and queue entry types for the AXI B-channel responder.
package axi_pkg;

    localparam int AXI_ID_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [AXI_ID_W-1:0] id_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_entry_t;

    typedef struct packed {
        id_t  id;
        logic dec_err;
    } aw_entry_t;

    // Decode error dominates; otherwise any storage error seen in the burst gives SLVERR.
    function automatic logic [1:0] b_resp_code(input logic dec_err, input logic burst_err);
        if (dec_err)        return RESP_DECERR;
        else if (burst_err) return RESP_SLVERR;
        else                return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_b_responder_if.sv
// AW/W/B handshake signals between a write master and the B responder.
interface axi_b_responder_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32
) ();
    // Every channel uses valid/ready: a transfer happens on a rising edge where both are 1,
    // and the source holds its payload stable while valid=1 and ready=0.
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport slave (
        input  AWID, AWADDR, AWVALID, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport master (
        output AWID, AWADDR, AWVALID, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/resp_fifo.sv
// Small synchronous FIFO with registered pointers/count and a zeroed head when empty.
module resp_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Callers only push when not full and only pop when not empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset, so an empty queue presents zero rather than stale data.
    assign head = (count != '0) ? mem[rd_ptr] : T'('0);

endmodule

// File: rtl/axi_b_responder.sv
// Slave-side AXI write-response generator: queues AW IDs, counts W beats to WLAST, issues B in order.
// Optional address decode error checking is enabled by defining AXI_B_DECERR_EN.
module axi_b_responder
    import axi_pkg::*;
#(
    parameter int              ID_W   = 8,
    parameter int              DEPTH  = 4,
    parameter int              ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] SIZE = 32'h0001_0000
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_b_responder_if.slave   bus,
    output logic               mem_we,
    input  logic               mem_err
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] aw_cnt;
    logic [CW-1:0] b_cnt;
    logic          aw_ready;
    logic          w_ready;
    logic          aw_fire;
    logic          w_fire;
    logic          wlast_fire;
    logic          b_pop;
    logic          head_dec_err;
    id_t           head_id;
    logic          err_acc;
    logic          beat_err;
    b_entry_t      b_push_data;
    b_entry_t      b_head;

    // Ready signals ignore any same-cycle pop so there is no input-to-ready path.
    assign aw_ready   = (aw_cnt != FULL);
    assign w_ready    = (aw_cnt != '0) && (b_cnt != FULL);
    assign aw_fire    = bus.AWVALID & aw_ready;
    assign w_fire     = bus.WVALID & w_ready;
    assign wlast_fire = w_fire & bus.WLAST;

`ifdef AXI_B_DECERR_EN
    localparam logic [ADDR_W:0] LO = {1'b0, BASE};
    localparam logic [ADDR_W:0] HI = {1'b0, BASE} + {1'b0, SIZE};

    aw_entry_t aw_push_data;
    aw_entry_t aw_head;
    logic      dec_err_in;

    // One extra bit so BASE+SIZE may reach the top of the address space without wrapping.
    assign dec_err_in        = ({1'b0, bus.AWADDR} < LO) || ({1'b0, bus.AWADDR} >= HI);
    assign aw_push_data.id      = AXI_ID_W'(bus.AWID);
    assign aw_push_data.dec_err = dec_err_in;
    assign head_id           = aw_head.id;
    assign head_dec_err      = aw_head.dec_err;

    resp_fifo #(.T(aw_entry_t), .DEPTH(DEPTH)) u_aw_q (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (aw_fire),
        .push_data (aw_push_data),
        .pop       (wlast_fire),
        .head      (aw_head),
        .count     (aw_cnt)
    );
`else
    id_t  aw_push_data;
    id_t  aw_head;
    logic unused_decode;

    assign unused_decode = ^{bus.AWADDR, BASE, SIZE};
    assign aw_push_data  = AXI_ID_W'(bus.AWID);
    assign head_id       = aw_head;
    assign head_dec_err  = 1'b0;

    resp_fifo #(.T(id_t), .DEPTH(DEPTH)) u_aw_q (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (aw_fire),
        .push_data (aw_push_data),
        .pop       (wlast_fire),
        .head      (aw_head),
        .count     (aw_cnt)
    );
`endif

    assign mem_we   = w_fire & ~head_dec_err;
    assign beat_err = mem_we & mem_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETn)        err_acc <= 1'b0;
        else if (wlast_fire) err_acc <= 1'b0;
        else if (w_fire)     err_acc <= err_acc | beat_err;
    end

    assign b_push_data.id   = head_id;
    assign b_push_data.resp = b_resp_code(head_dec_err, err_acc | beat_err);
    assign b_pop            = (b_cnt != '0) & bus.BREADY;

    resp_fifo #(.T(b_entry_t), .DEPTH(DEPTH)) u_b_q (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (wlast_fire),
        .push_data (b_push_data),
        .pop       (b_pop),
        .head      (b_head),
        .count     (b_cnt)
    );

    assign bus.AWREADY = aw_ready;
    assign bus.WREADY  = w_ready;
    assign bus.BVALID  = (b_cnt != '0);
    assign bus.BID     = ID_W'(b_head.id);
    assign bus.BRESP   = b_head.resp;

endmodule

// File: tb/tb_axi_b_responder.sv
// Directed bench for axi_b_responder: ordering, error accumulation, W-before-AW, stall and reset.
module tb_axi_b_responder;

    logic clk = 1'b0;
    logic ARESETn;
    logic mem_we;
    logic mem_err;

    int checks = 0;
    int errors = 0;

    axi_b_responder_if #(.ID_W(8), .ADDR_W(32)) bus ();

    axi_b_responder #(.ID_W(8), .DEPTH(4), .ADDR_W(32)) dut (
        .ACLK    (clk),
        .ARESETn (ARESETn),
        .bus     (bus),
        .mem_we  (mem_we),
        .mem_err (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETn     = 1'b0;
        bus.AWID    = '0;
        bus.AWADDR  = '0;
        bus.AWVALID = 1'b0;
        bus.WLAST   = 1'b0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        mem_err     = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;

        // Reset state
        check("rst_bvalid",  32'(bus.BVALID),  32'd0);
        check("rst_bid",     32'(bus.BID),     32'd0);
        check("rst_bresp",   32'(bus.BRESP),   32'd0);
        check("rst_awready", 32'(bus.AWREADY), 32'd1);
        check("rst_wready",  32'(bus.WREADY),  32'd0);
        check("rst_mem_we",  32'(mem_we),      32'd0);

        // Single beat burst
        bus.BREADY  = 1'b1;
        bus.AWID    = 8'h15;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b1;
        bus.WLAST   = 1'b1;
        #1;
        check("t1_wready", 32'(bus.WREADY), 32'd1);
        check("t1_mem_we", 32'(mem_we),     32'd1);
        check("t1_bvalid_before", 32'(bus.BVALID), 32'd0);
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("t1_bvalid", 32'(bus.BVALID), 32'd1);
        check("t1_bid",    32'(bus.BID),    32'h15);
        check("t1_bresp",  32'(bus.BRESP),  32'd0);
        tick();
        check("t1_bpulse", 32'(bus.BVALID), 32'd0);

        // Ordering with full queues
        bus.BREADY = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.AWID    = 8'(i);
            bus.AWVALID = 1'b1;
            tick();
        end
        bus.AWVALID = 1'b0;
        #1;
        check("t2_awready_full", 32'(bus.AWREADY), 32'd0);
        bus.WVALID = 1'b1;
        bus.WLAST  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("t2_bvalid", 32'(bus.BVALID), 32'd1);
        bus.AWID    = 8'h05;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        #1;
        check("t2_wready_bfull", 32'(bus.WREADY), 32'd0);
        bus.BREADY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("t2_order_bvalid", 32'(bus.BVALID), 32'd1);
            check("t2_order_bid",    32'(bus.BID),    32'(i));
            check("t2_order_bresp",  32'(bus.BRESP),  32'd0);
            tick();
        end
        check("t2_drained",     32'(bus.BVALID), 32'd0);
        check("t2_wready_free", 32'(bus.WREADY), 32'd1);

        // Error accumulation: 4 beats on ID 5, error on beat 2
        for (int beat = 1; beat <= 4; beat++) begin
            bus.WVALID = 1'b1;
            bus.WLAST  = (beat == 4);
            mem_err    = (beat == 2);
            tick();
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        mem_err    = 1'b0;
        check("t3_bvalid", 32'(bus.BVALID), 32'd1);
        check("t3_bid",    32'(bus.BID),    32'h05);
        check("t3_slverr", 32'(bus.BRESP),  32'h2);
        bus.AWID    = 8'h06;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b1;
        tick();
        bus.WLAST = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("t3_clean_bid",  32'(bus.BID),   32'h06);
        check("t3_clean_okay", 32'(bus.BRESP), 32'h0);
        bus.AWID    = 8'h07;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b1;
        bus.WLAST   = 1'b1;
        mem_err     = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        mem_err    = 1'b0;
        check("t3_last_bid",    32'(bus.BID),   32'h07);
        check("t3_last_slverr", 32'(bus.BRESP), 32'h2);
        tick();

        // W before AW
        bus.WVALID = 1'b1;
        bus.WLAST  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_wready_hold", 32'(bus.WREADY), 32'd0);
            check("t4_mem_we_hold", 32'(mem_we),     32'd0);
            tick();
        end
        bus.AWID    = 8'h08;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        #1;
        check("t4_wready_open", 32'(bus.WREADY), 32'd1);
        check("t4_mem_we",      32'(mem_we),     32'd1);
        tick();
        bus.WLAST = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("t4_bvalid", 32'(bus.BVALID), 32'd1);
        check("t4_bid",    32'(bus.BID),    32'h08);
        tick();

        // Stall then reset with entries queued
        bus.BREADY = 1'b0;
        bus.AWID    = 8'h09;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWID = 8'h0A;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b1;
        bus.WLAST   = 1'b1;
        tick();
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_stall_bvalid", 32'(bus.BVALID), 32'd1);
            check("t5_stall_bid",    32'(bus.BID),    32'h09);
            check("t5_stall_bresp",  32'(bus.BRESP),  32'd0);
            tick();
        end
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        check("t5_rst_bvalid",  32'(bus.BVALID),  32'd0);
        check("t5_rst_awready", 32'(bus.AWREADY), 32'd1);
        check("t5_rst_bid",     32'(bus.BID),     32'd0);
        check("t5_rst_wready",  32'(bus.WREADY),  32'd0);
        tick();
        check("t5_no_stale_b", 32'(bus.BVALID), 32'd0);

`ifdef AXI_B_DECERR_EN
        // Address decode: out of range then just inside
        bus.BREADY  = 1'b1;
        bus.AWID    = 8'h20;
        bus.AWADDR  = 32'h0001_0000;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b1;
        bus.WLAST   = 1'b0;
        #1;
        check("t6_dec_we1", 32'(mem_we), 32'd0);
        tick();
        bus.WLAST = 1'b1;
        #1;
        check("t6_dec_we2", 32'(mem_we), 32'd0);
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("t6_dec_bid",   32'(bus.BID),   32'h20);
        check("t6_dec_bresp", 32'(bus.BRESP), 32'h3);
        tick();
        bus.AWID    = 8'h21;
        bus.AWADDR  = 32'h0000_FFFC;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b1;
        bus.WLAST   = 1'b1;
        #1;
        check("t6_in_we", 32'(mem_we), 32'd1);
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        check("t6_in_bid",   32'(bus.BID),   32'h21);
        check("t6_in_bresp", 32'(bus.BRESP), 32'h0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
